// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: presents a word on d, steps s through 0..3 with a
// programmable dwell, reassembles the mux output into rx and flags mismatches.
module mux_scan_ctrl #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] word,
    output logic       ready,
    output logic [3:0] d,
    output logic [1:0] s,
    input  logic       y,
    output logic       bit_valid,
    output logic [3:0] rx,
    output logic       done,
    output logic       err
);

    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("mux_scan_ctrl: DWELL must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_cnt;

    assign last_cnt = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        bit_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                bit_valid = last_cnt;
                if (last_cnt && s == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // y is sampled in the same cycle s is presented; the mux is purely combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d   <= 4'd0;
            s   <= 2'd0;
            rx  <= 4'd0;
            cnt <= 4'd0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d   <= word;
                        s   <= 2'd0;
                        cnt <= 4'd0;
                        rx  <= 4'd0;
                        err <= 1'b0;
                    end
                end
                SCAN: begin
                    if (last_cnt) begin
                        rx[s] <= y;
                        cnt   <= 4'd0;
                        if (s != 2'd3) s <= s + 2'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    err <= (rx != d);
                    s   <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 4:1 behavioural mux (`mux_beha`) and drives its `d` and `s` inputs. It accepts a 4-bit word through a ready/start handshake and presents it on `d`. It steps `s` through 00→01→10→11, holding each select for a programmable dwell. It samples the mux output `y` back into a reassembled word and flags any mismatch, giving the lab a self-checking scan of the mux.

## Interface
Parameters:
- DWELL, default 1: clock cycles each select value is held. Legal range is 1..15; anything else is a configuration error.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request to scan `word`; accepted only in a cycle where `ready`=1
- word  in  4  word to scan, sampled on the accepting edge
- ready  out  1  high only in IDLE
- d  out  4  registered data to mux `d`
- s  out  2  registered select to mux `s`
- y  in  1  mux output, fed back
- bit_valid  out  1  high in the last dwell cycle of each select, which is the cycle `y` is sampled
- rx  out  4  reassembled word; `rx[i]` takes `y` sampled while `s`=i
- done  out  1  one-cycle pulse when a scan completes
- err  out  1  registered; 1 if `rx`≠`d` at completion

## Operation
States: IDLE, SCAN, DONE. A 4-bit dwell counter `cnt` runs in SCAN.

- **Reset (async, any state):** state=IDLE, d=0, s=0, rx=0, cnt=0, done=0, err=0. Combinational decodes then give ready=1 and bit_valid=0.
- **IDLE:**
  - ready=1.
  - If start=1 at an edge: d←word, s←0, cnt←0, rx←0, err←0, state→SCAN.
  - Otherwise all registers hold.
- **SCAN:**
  - ready=0.
  - bit_valid = (cnt==DWELL-1).
  - On an edge with cnt<DWELL-1: cnt←cnt+1.
  - On an edge with cnt==DWELL-1: rx[s]←y and cnt←0.
    - If s<3: s←s+1.
    - If s==3: s holds at 3 and state→DONE.
- **DONE:**
  - done=1 for exactly this one cycle; ready=0.
  - Next edge: err←(rx≠d), state→IDLE, s←0.
  - d and rx hold until the next accept, so the result stays readable.
- `done` is a combinational decode of state==DONE. `err` becomes valid from the IDLE cycle after `done` and holds until the next accept clears it.
- `start` outside IDLE is ignored; no queuing.
- `word` changes outside the accepting edge have no effect; `d` is stable for the entire scan.
- Arithmetic: `cnt` is 4-bit and never exceeds DWELL-1. `s` never wraps within a scan; its 3→0 transition happens only on the DONE→IDLE edge.

## Timing
Edge numbering: E0 is the accepting edge.

- Scan phase: SCAN covers E0..E(4·DWELL). `s`=i for cycles E(i·DWELL)..E((i+1)·DWELL).
- Samples: `y` is sampled at edges E((i+1)·DWELL), i=0..3.
- Completion: `done` is high in the cycle after E(4·DWELL). IDLE (ready=1) begins after E(4·DWELL+1).
- Throughput: with `start` held high, accepts occur every 4·DWELL+2 cycles. For DWELL=1 the accept edges are E0, E6, E12, …
- Mux path: the mux is combinational, so `y` settles within the same cycle `s` changes. No extra pipeline cycle is allowed between `s` and its sample.
- Reset mid-scan: the scan aborts immediately, `done` is never pulsed for it, and the first legal accept is at the first edge after `rst` deasserts.
- Start during the DONE cycle: ignored.

## Test plan
- **Basic scan:** DWELL=1 with the real mux in loopback; start with word=4'b1010. Required: s=0,1,2,3 in cycles E0–E4; bit_valid high on each; done in cycle E4–E5; rx=4'b1010; err=0.
- **Fault injection:** force y=0 and scan word=4'b1010. Required: rx=4'b0000, err=1 after done. Then release the force, scan 4'b0110, and require err=0.
- **Dwell:** DWELL=3, word=4'b0001. Required: each s value held 3 cycles; bit_valid only on the 3rd cycle of each; done after E12; rx=4'b0001.
- **Busy/back-to-back:** start pulsed again mid-scan with word=4'b1111 → ignored, and the current scan completes with its original word. Then hold start high with word=4'b0101 → accepts every 6 cycles (DWELL=1), each finishing with rx=4'b0101, err=0.
- **Reset mid-scan:** assert rst while s=2. Required: d=0, s=0, rx=0, err=0, ready=1 immediately (async); no done pulse. After release, a scan of 4'b1100 completes correctly.
